// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU front-end blocks (button indices,
// default debounce / auto-repeat timing at 100 MHz) and a small helper.
package alu_pkg;

  // Button channel indices on the Nexys board
  localparam int BTN_L = 0;
  localparam int BTN_C = 1;
  localparam int BTN_R = 2;

  // Default timing at 100 MHz
  localparam int DEBOUNCE_10MS       = 1000000;
  localparam int REPEAT_DELAY_500MS  = 50000000;
  localparam int REPEAT_PERIOD_100MS = 10000000;

  // Larger of two integers, used to size shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: groups the raw button inputs with their debounced
// level and press strobe.
//
// Handshake: there is no valid/ready pair. btn is sampled on every rising
// clock edge; level is a held value; pulse is a single-cycle strobe that the
// consumer must act on in the cycle it is high (no back-pressure).
interface btn_conditioner_if #(
  parameter int N = 3
);
  logic [N-1:0] btn;
  logic [N-1:0] level;
  logic [N-1:0] pulse;

  modport master (output btn, input level, input pulse);
  modport slave  (input btn, output level, output pulse);
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel. Two-flop synchroniser, persistence
// counter, stable-level flop and registered press strobe.
// Optional feature macro: BTN_AUTOREPEAT_EN adds held-button auto-repeat
// strobes (first after REPEAT_DELAY, then every REPEAT_PERIOD cycles).
module btn_debounce_ch
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  btn_conditioner_if.slave   ch
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          accept;
  logic          rise;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ch.btn;
      sync2_q <= sync1_q;
    end
  end

  // Persistence count: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive samples that differ from the stable value
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      accept   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = accept & sync2_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            RW       = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q;
  logic          rep_first_q;
  logic          rep_fire;

  // A repeat never fires in the cycle the level is falling (accept while high)
  assign rep_fire = stable_q & ~accept &
                    (rep_cnt_q == (rep_first_q ? DLY_LAST : PER_LAST));

  // Repeat timer: restarts on the press, runs while held, cleared on release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rise || !stable_q || accept) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_q + 1'b1;
    end
  end

  assign pulse_d = rise | rep_fire;
`else
  assign pulse_d = rise;
`endif

  // Register the stable level, counter and strobe so outputs are glitch-free
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign ch.level = stable_q;
  assign ch.pulse = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent debounced push-button channels, each
// producing a clean level and a one-cycle press strobe for the ALU loads.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while held).
module btn_conditioner
  import alu_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_100MS
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_pulse
);

  // One channel per button; channels share nothing but clock and reset
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_conditioner_if #(.N(1)) ch_if ();

    assign ch_if.btn      = i_btn[g];
    assign o_btn_level[g] = ch_if.level;
    assign o_btn_pulse[g] = ch_if.pulse;

    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk_i  (CLK100MHZ),
      .rst_ni (CPU_RESETN),
      .ch     (ch_if.slave)
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and randomized checks of btn_conditioner
// against a window-based behavioural model.
module tb_btn_conditioner;
  import alu_pkg::*;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_conditioner_if #(.N(N)) bus ();

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .i_btn       (bus.btn),
    .o_btn_level (bus.level),
    .o_btn_pulse (bus.pulse)
  );

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 30) begin
        fail_prints++;
        $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  // A button's level flips once the last D synchronised samples all differ
  // from the current level. Strobes: the press, then (auto-repeat builds)
  // press+RD and every RP after, while the level stays high.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pul;
  int           m_age [N];
  logic         m_win [N][$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pul = '0;
      for (int c = 0; c < N; c++) begin
        m_age[c] = 0;
        m_win[c].delete();
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        logic prev;
        bit   flip;
        m_win[c].push_back(m_s2[c]);
        if (m_win[c].size() > D) void'(m_win[c].pop_front());
        prev = m_lvl[c];
        flip = (m_win[c].size() == D);
        for (int k = 0; k < m_win[c].size(); k++)
          if (m_win[c][k] == prev) flip = 0;
        if (flip) m_lvl[c] = ~prev;
        m_pul[c] = 1'b0;
        if (m_lvl[c] && !prev) begin
          m_pul[c] = 1'b1;
          m_age[c] = 0;
        end else if (m_lvl[c] && prev) begin
          m_age[c]++;
`ifdef BTN_AUTOREPEAT_EN
          if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
            m_pul[c] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.btn;
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    logic [2*N-1:0] exp_v;
    exp_v = rst_n ? {m_lvl, m_pul} : '0;
    check("cycle_level_pulse", 32'({bus.level, bus.pulse}), 32'(exp_v));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watch ncyc edges; e=1 is the sample just after the first edge.
  task automatic obs(input int ncyc, output int rise_e[N], output int npul[N],
                     output int fall_e[N], output logic [N-1:0] first_vec);
    logic [N-1:0] prev_lvl;
    prev_lvl  = bus.level;
    first_vec = '0;
    for (int c = 0; c < N; c++) begin
      rise_e[c] = -1; npul[c] = 0; fall_e[c] = -1;
    end
    for (int e = 1; e <= ncyc; e++) begin
      @(posedge clk);
      #1;
      if (first_vec == '0) first_vec = bus.pulse;
      for (int c = 0; c < N; c++) begin
        if (bus.pulse[c]) begin
          npul[c]++;
          if (rise_e[c] < 0) rise_e[c] = e;
        end
        if (prev_lvl[c] && !bus.level[c] && fall_e[c] < 0) fall_e[c] = e;
      end
      prev_lvl = bus.level;
    end
  endtask

  // ---------------- test sequence ----------------
  int           rise_e [N];
  int           npul   [N];
  int           fall_e [N];
  logic [N-1:0] fv;
  logic [7:0]   exp_q [$];
  logic [7:0]   got_q [$];

  initial begin
    bus.btn = 3'b111;
    rst_n   = 1'b0;
    tick(3);
    check("reset_level", 32'(bus.level), 32'h0);
    check("reset_pulse", 32'(bus.pulse), 32'h0);

    // Buttons held through reset release: treated as a new press
    rst_n = 1'b1;
    obs(12, rise_e, npul, fall_e, fv);
    check("rst_hold_first_vec", 32'(fv), 32'h7);
    for (int c = 0; c < N; c++) begin
      check("rst_hold_rise_edge", 32'(rise_e[c]), 32'd6);
      check("rst_hold_one_strobe", 32'(npul[c]), 32'd1);
    end
    check("rst_hold_level", 32'(bus.level), 32'h7);

    // Release: level falls 6 edges later, no strobe
    bus.btn = 3'b000;
    obs(12, rise_e, npul, fall_e, fv);
    for (int c = 0; c < N; c++) begin
      check("release_fall_edge", 32'(fall_e[c]), 32'd6);
      check("release_no_strobe", 32'(npul[c]), 32'd0);
    end

    // Clean press on btnC
    bus.btn = 3'b010;
    obs(12, rise_e, npul, fall_e, fv);
    check("clean_rise_edge", 32'(rise_e[BTN_C]), 32'd6);
    check("clean_one_strobe", 32'(npul[BTN_C]), 32'd1);
    check("clean_other_L", 32'(npul[BTN_L]), 32'd0);
    check("clean_other_R", 32'(npul[BTN_R]), 32'd0);
    check("clean_level", 32'(bus.level), 32'h2);
    bus.btn = 3'b000;
    tick(10);

    // Bounce on btnL: high 3, low 1, high 2, low
    begin
      logic pat [6];
      int   seen;
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        bus.btn[BTN_L] = pat[k];
        tick(1);
        seen += int'(bus.level[BTN_L]) + int'(bus.pulse[BTN_L]);
      end
      bus.btn[BTN_L] = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick(1);
        seen += int'(bus.level[BTN_L]) + int'(bus.pulse[BTN_L]);
      end
      check("bounce_rejected", 32'(seen), 32'd0);
    end

    // Simultaneous press of btnL and btnR
    bus.btn = 3'b101;
    obs(12, rise_e, npul, fall_e, fv);
    check("simul_vec", 32'(fv), 32'h5);
    check("simul_rise_L", 32'(rise_e[BTN_L]), 32'd6);
    check("simul_rise_R", 32'(rise_e[BTN_R]), 32'd6);
    check("simul_C_quiet", 32'(rise_e[BTN_C]), 32'hffff_ffff);
    bus.btn = 3'b000;
    obs(12, rise_e, npul, fall_e, fv);
    check("simul_release_no_strobe", 32'(npul[BTN_L] + npul[BTN_R]), 32'd0);

    // Re-press after a full debounce
    bus.btn = 3'b001;
    obs(12, rise_e, npul, fall_e, fv);
    check("repress_one_strobe", 32'(npul[BTN_L]), 32'd1);
    bus.btn = 3'b000;
    tick(10);

    // Hold btnR; release so that the level falls exactly at P+35
    begin
      int p_wait;
      bit found;
      bus.btn = 3'b100;
      found = 0;
      p_wait = 0;
      while (!found && p_wait < 20) begin
        tick(1);
        p_wait++;
        if (bus.pulse[BTN_R]) found = 1;
      end
      check("repeat_press_seen", 32'(found), 32'd1);
      check("repeat_press_edge", 32'(p_wait), 32'd6);
      exp_q.delete();
      got_q.delete();
      exp_q.push_back(8'd0);
`ifdef BTN_AUTOREPEAT_EN
      exp_q.push_back(8'd10); exp_q.push_back(8'd15); exp_q.push_back(8'd20);
      exp_q.push_back(8'd25); exp_q.push_back(8'd30);
`endif
      got_q.push_back(8'd0);
      for (int off = 1; off <= 50; off++) begin
        tick(1);
        if (bus.pulse[BTN_R]) got_q.push_back(8'(off));
        if (off == 34) check("repeat_level_held", 32'(bus.level[BTN_R]), 32'd1);
        if (off == 35) check("repeat_level_fell", 32'(bus.level[BTN_R]), 32'd0);
        if (off == 29) bus.btn = 3'b000;
      end
      check("repeat_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        check("repeat_offset", 32'(got_q[k]), 32'(exp_q[k]));
    end

    // Randomized traffic with occasional mid-run resets
    for (int it = 0; it < 1200; it++) begin
      int hold;
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      bus.btn = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 28) : $urandom_range(1, 5);
      tick(hold);
    end
    bus.btn = 3'b000;
    tick(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the raw Nexys push-buttons (btnL, btnC, btnR) before they reach the ALU operand/opcode load registers. Each button is synchronised to CLK100MHZ, debounced with a persistence counter, and reduced to a clean level plus a one-cycle press strobe. The strobes drive the load enables of the ALU top level, so one physical press loads exactly once.

## Interface
- N_BTN, 3, number of button channels; bit 0 = btnL, bit 1 = btnC, bit 2 = btnR
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a change (10 ms at 100 MHz); legal range ≥ 2
- REPEAT_DELAY, 50000000, cycles from press strobe to first auto-repeat strobe (used only with BTN_AUTOREPEAT_EN); ≥ 2
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes; ≥ 2

- CLK100MHZ  input  1  system clock; the single clock, all flops on its rising edge
- CPU_RESETN  input  1  asynchronous, active-low reset
- i_btn  input  N_BTN  raw asynchronous button inputs, active-high
- o_btn_level  output  N_BTN  debounced button level
- o_btn_pulse  output  N_BTN  one-cycle press strobe per button

## Operation
- Channels are fully independent; no cross-channel priority.
- Per channel: 2-flop synchroniser (sync1, sync2), stable-state flop, debounce counter, pulse flop.
- Debounce counter width: $clog2(DEBOUNCE_CYCLES).
- sync2 == stable: counter cleared to 0.
- sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
- sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable takes sync2, counter cleared.
- Any bounce back to the stable value restarts the count from 0.
- o_btn_level = stable.
- o_btn_pulse asserts for exactly one cycle on the edge where stable goes 0→1.
- No strobe on release (1→0).
- Reset: sync1, sync2, stable, counters, o_btn_level, o_btn_pulse all 0.
- A button held through reset deassertion is treated as a new press: after debounce it produces level 1 and one strobe.
- Reset asserted mid-count or mid-repeat clears everything immediately. No strobe is generated by the reset itself.

## Timing
- Latency: edge 0 is the first edge sampling the new i_btn value. o_btn_level and o_btn_pulse update after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total. Release follows the same latency.
- o_btn_pulse and the rising o_btn_level appear in the same cycle.
- Input glitch shorter than DEBOUNCE_CYCLES cycles (as seen at sync2): no output change.
- Outputs are registered and glitch-free. There is no combinational path from i_btn to any output.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - Per-channel repeat counter, width $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
  - Counter clears on the press strobe and counts while o_btn_level = 1.
  - Extra strobes at press+REPEAT_DELAY, then every REPEAT_PERIOD cycles while held.
  - Release clears the counter at once. A strobe is never issued in the cycle level falls.
- BTN_AUTOREPEAT_EN undefined: no repeat logic is synthesised; exactly one strobe per accepted press.

## Structure
- Shared package/header alu_pkg holds:
  - button index constants BTN_L=0, BTN_C=1, BTN_R=2
  - default timing constants DEBOUNCE_10MS=1000000, REPEAT_DELAY_500MS=50000000, REPEAT_PERIOD_100MS=10000000
- Sub-module btn_debounce_ch: one channel (synchroniser, counter, stable flop, pulse, optional repeat). It is instantiated N_BTN times in a generate loop by btn_conditioner.

## Test plan
All cases use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
- Reset: CPU_RESETN low with i_btn=3'b111 → o_btn_level=0 and o_btn_pulse=0. Release reset with the buttons still held → level goes to 3'b111 and a single strobe on each bit, 6 edges later.
- Clean press: i_btn[1] rises before edge 0 and holds → o_btn_level[1]=1 and o_btn_pulse[1]=1 after edge 5. Pulse is 0 after edge 6; other bits stay 0.
- Bounce rejection: i_btn[0] toggles high 3 cycles, low 1, high 2, low → o_btn_level[0] never rises; no strobe.
- Simultaneous presses: i_btn 3'b000→3'b101 at the same edge → bits 0 and 2 strobe together in the same cycle; bit 1 stays 0.
- Release: held button released → o_btn_level falls 6 edges after release; no strobe. Re-press after a full debounce → a new single strobe.
- Auto-repeat (BTN_AUTOREPEAT_EN defined): hold i_btn[2] for 30 cycles after its press strobe at cycle P → strobes at P, P+10, P+15, P+20, P+25, P+30. Release → no further strobes. With the macro undefined → a single strobe at P only.
